// File: rtl/tetris_play_ctrl_if.sv
// Control pulses from the input/tick logic and the board/piece view consumed by the grid renderer.
// Master drives the pulses; slave is the play controller.
interface tetris_play_ctrl_if #(
  parameter int ROWS = 20,
  parameter int COLS = 10
);
  logic                       start;
  logic                       tick;
  logic                       left;
  logic                       right;
  logic [ROWS*COLS*3-1:0]     display_array;
  logic [4:0]                 piece_row;
  logic [3:0]                 piece_col;
  logic [15:0]                lines_cleared;
  logic                       game_over;
  logic                       busy;

  modport master (
    output start, tick, left, right,
    input  display_array, piece_row, piece_col, lines_cleared, game_over, busy
  );

  modport slave (
    input  start, tick, left, right,
    output display_array, piece_row, piece_col, lines_cleared, game_over, busy
  );
endinterface

// File: rtl/tetris_play_ctrl.sv
// Tetris play sequencer: owns the board, moves/drops a 2x2 piece, locks it and clears full lines one row per cycle.
// Display is combinational from registers; pulses arriving while busy, idle or game-over are dropped.
module tetris_play_ctrl #(
  parameter int         ROWS        = 20,
  parameter int         COLS        = 10,
  parameter logic [2:0] PIECE_COLOR = 3'b100,
  parameter int         SPAWN_COL   = 4
) (
  input  logic               clk,
  input  logic               rst,
  tetris_play_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CLR, SPAWN, FALL, LOCK, SCAN, SHIFT, GAME_OVER} state_t;
  typedef logic [ROWS-1:0][COLS-1:0][2:0] board_t;

  localparam logic [4:0] ROW_LIMIT = 5'(ROWS - 2);
  localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
  localparam logic [3:0] COL_LIMIT = 4'(COLS - 2);
  localparam logic [3:0] SPAWN_C   = 4'(SPAWN_COL);
  localparam logic [3:0] SPAWN_C1  = 4'(SPAWN_COL + 1);

  state_t      state_q, state_d;
  board_t      board_q, board_d;
  logic [4:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [4:0]  scan_q, scan_d;
  logic [15:0] lines_q, lines_d;

  logic [4:0]  row_p1, row_p2;
  logic [3:0]  col_m1, col_p1, col_p2;
  logic        row_full;
  board_t      disp;

  assign row_p1 = row_q + 5'd1;
  assign row_p2 = row_q + 5'd2;
  assign col_m1 = col_q - 4'd1;
  assign col_p1 = col_q + 4'd1;
  assign col_p2 = col_q + 4'd2;

  function automatic logic occ(input board_t b, input logic [4:0] r, input logic [3:0] c);
    return |b[r][c];
  endfunction

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (board_q[scan_q][c] == 3'b000) row_full = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      board_q <= '0;
      row_q   <= '0;
      col_q   <= SPAWN_C;
      scan_q  <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      row_q   <= row_d;
      col_q   <= col_d;
      scan_q  <= scan_d;
      lines_q <= lines_d;
    end
  end

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    row_d   = row_q;
    col_d   = col_q;
    scan_d  = scan_q;
    lines_d = lines_q;
    case (state_q)
      IDLE, GAME_OVER: if (bus.start) state_d = CLR;
      CLR: begin
        board_d = '0;
        lines_d = '0;
        state_d = SPAWN;
      end
      SPAWN: begin
        row_d = '0;
        col_d = SPAWN_C;
        if (occ(board_q, 5'd0, SPAWN_C) || occ(board_q, 5'd0, SPAWN_C1) ||
            occ(board_q, 5'd1, SPAWN_C) || occ(board_q, 5'd1, SPAWN_C1))
          state_d = GAME_OVER;
        else
          state_d = FALL;
      end
      FALL: begin
        // Bounds are tested first so the +2 / -1 indices are never evaluated off the board.
        if (bus.tick) begin
          if (row_q < ROW_LIMIT && !occ(board_q, row_p2, col_q) && !occ(board_q, row_p2, col_p1))
            row_d = row_p1;
          else
            state_d = LOCK;
        end else if (bus.left && !bus.right) begin
          if (col_q != 4'd0 && !occ(board_q, row_q, col_m1) && !occ(board_q, row_p1, col_m1))
            col_d = col_m1;
        end else if (bus.right && !bus.left) begin
          if (col_q < COL_LIMIT && !occ(board_q, row_q, col_p2) && !occ(board_q, row_p1, col_p2))
            col_d = col_p1;
        end
      end
      LOCK: begin
        board_d[row_q][col_q]   = PIECE_COLOR;
        board_d[row_q][col_p1]  = PIECE_COLOR;
        board_d[row_p1][col_q]  = PIECE_COLOR;
        board_d[row_p1][col_p1] = PIECE_COLOR;
        scan_d  = LAST_ROW;
        state_d = SCAN;
      end
      SCAN: begin
        if (row_full)
          state_d = SHIFT;
        else if (scan_q == 5'd0)
          state_d = SPAWN;
        else
          scan_d = scan_q - 5'd1;
      end
      SHIFT: begin
        // scan_row is kept so the row that just moved down is checked again.
        for (int k = 1; k < ROWS; k++) begin
          if (5'(k) <= scan_q) board_d[k] = board_q[k-1];
        end
        board_d[0] = '0;
        lines_d    = lines_q + 16'd1;
        state_d    = SCAN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    disp = board_q;
    if (state_q == FALL) begin
      disp[row_q][col_q]   = PIECE_COLOR;
      disp[row_q][col_p1]  = PIECE_COLOR;
      disp[row_p1][col_q]  = PIECE_COLOR;
      disp[row_p1][col_p1] = PIECE_COLOR;
    end
  end

  assign bus.display_array = disp;
  assign bus.piece_row     = row_q;
  assign bus.piece_col     = col_q;
  assign bus.lines_cleared = lines_q;
  assign bus.game_over     = (state_q == GAME_OVER);
  assign bus.busy          = (state_q == CLR) || (state_q == LOCK) ||
                             (state_q == SCAN) || (state_q == SHIFT);

endmodule

// File: tb/tb_tetris_play_ctrl.sv
// Bench for tetris_play_ctrl: directed scenarios plus random pulse streams against a game-level model.
module tb_tetris_play_ctrl;
  localparam int         ROWS      = 20;
  localparam int         COLS      = 10;
  localparam int         SPAWN_COL = 4;
  localparam logic [2:0] PC        = 3'b100;
  localparam int         W         = ROWS*COLS*3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tetris_play_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  tetris_play_ctrl #(.ROWS(ROWS), .COLS(COLS), .PIECE_COLOR(PC), .SPAWN_COL(SPAWN_COL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Game-level model: settled board contents, piece position, line total.
  int mb [ROWS][COLS];
  int mrow, mcol, mlines;
  bit mplay, mover;

  function automatic logic [W-1:0] exp_disp();
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[(r*COLS+c)*3 +: 3] = 3'(mb[r][c]);
    if (mplay)
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          v[((mrow+dr)*COLS + mcol+dc)*3 +: 3] = PC;
    return v;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mb[r][c] = 0;
  endfunction

  function automatic void model_spawn();
    mrow = 0;
    mcol = SPAWN_COL;
    if (mb[0][mcol] != 0 || mb[0][mcol+1] != 0 || mb[1][mcol] != 0 || mb[1][mcol+1] != 0) begin
      mover = 1'b1; mplay = 1'b0;
    end else begin
      mover = 1'b0; mplay = 1'b1;
    end
  endfunction

  // Stamp the piece, then compact the board by dropping every full row.
  function automatic int model_lock();
    int nb [ROWS][COLS];
    int dst;
    int k;
    bit full;
    dst = ROWS - 1;
    k = 0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        mb[mrow+dr][mcol+dc] = int'(PC);
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (mb[r][c] == 0) full = 1'b0;
      if (full) k++;
      else begin
        for (int c = 0; c < COLS; c++) nb[dst][c] = mb[r][c];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--)
      for (int c = 0; c < COLS; c++) nb[r][c] = 0;
    mb = nb;
    mlines = (mlines + k) % 65536;
    return k;
  endfunction

  function automatic bit model_move(input bit t, input bit l, input bit r);
    if (t) begin
      if (mrow < ROWS-2 && mb[mrow+2][mcol] == 0 && mb[mrow+2][mcol+1] == 0) mrow++;
      else return 1'b1;
    end else if (l && r) begin
    end else if (l) begin
      if (mcol > 0 && mb[mrow][mcol-1] == 0 && mb[mrow+1][mcol-1] == 0) mcol--;
    end else if (r) begin
      if (mcol < COLS-2 && mb[mrow][mcol+2] == 0 && mb[mrow+1][mcol+2] == 0) mcol++;
    end
    return 1'b0;
  endfunction

  task automatic drive(input bit s, input bit t, input bit l, input bit r);
    @(negedge clk);
    bus.start = s; bus.tick = t; bus.left = l; bus.right = r;
    @(negedge clk);
    bus.start = 1'b0; bus.tick = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
  endtask

  // Counts busy cycles until the controller leaves LOCK/SCAN/SHIFT, then steps past SPAWN.
  task automatic settle(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic step(input bit s, input bit t, input bit l, input bit r,
                      output bit locked, output int k, output int cyc);
    drive(s, t, l, r);
    locked = 1'b0; k = 0; cyc = 0;
    if (mplay) begin
      locked = model_move(t, l, r);
      if (locked) begin
        k = model_lock();
        model_spawn();
        settle(cyc);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.tick = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    mplay = 1'b0; mover = 1'b0; mrow = 0; mcol = SPAWN_COL; mlines = 0;
  endtask

  task automatic do_start();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    model_clear();
    mlines = 0;
    model_spawn();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic drop_at(input int col, output int k, output int cyc);
    bit lk;
    int kk, cc;
    k = 0; cyc = 0;
    for (int i = 0; i < COLS && mcol > col; i++) step(0, 0, 1, 0, lk, kk, cc);
    for (int i = 0; i < COLS && mcol < col; i++) step(0, 0, 0, 1, lk, kk, cc);
    lk = 1'b0;
    for (int i = 0; i < ROWS + 2 && !lk; i++) step(0, 1, 0, 0, lk, k, cyc);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.display_array !== '0) begin n_fail++; $display("FAIL reset_board: got %h expected 0", bus.display_array); end
    n_checks++; if (bus.piece_row !== 5'd0) begin n_fail++; $display("FAIL reset_row: got %0d expected 0", bus.piece_row); end
    n_checks++; if (bus.piece_col !== 4'(SPAWN_COL)) begin n_fail++; $display("FAIL reset_col: got %0d expected %0d", bus.piece_col, SPAWN_COL); end
    n_checks++; if (bus.lines_cleared !== 16'd0) begin n_fail++; $display("FAIL reset_lines: got %0d expected 0", bus.lines_cleared); end
    n_checks++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b expected 0", bus.game_over); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    drive(0, 1, 1, 0);
    n_checks++; if (bus.busy !== 1'b0 || bus.display_array !== '0) begin n_fail++; $display("FAIL idle_ignore: busy %b board %h expected idle and empty", bus.busy, bus.display_array); end
  endtask

  task automatic test_start();
    drive(1, 0, 0, 0);
    model_clear(); mlines = 0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL start_clr_busy: got %b expected 1", bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.display_array !== '0) begin n_fail++; $display("FAIL start_spawn: busy %b board %h expected 0 and empty", bus.busy, bus.display_array); end
    model_spawn();
    @(negedge clk);
    n_checks++; if (bus.display_array !== exp_disp()) begin n_fail++; $display("FAIL start_fall_disp: got %h expected %h", bus.display_array, exp_disp()); end
    n_checks++; if (bus.piece_row !== 5'd0 || bus.piece_col !== 4'(SPAWN_COL)) begin n_fail++; $display("FAIL start_pos: got (%0d,%0d) expected (0,%0d)", bus.piece_row, bus.piece_col, SPAWN_COL); end
  endtask

  task automatic test_gravity();
    bit lk;
    int k, cyc;
    for (int i = 0; i < 18; i++) step(0, 1, 0, 0, lk, k, cyc);
    n_checks++; if (bus.piece_row !== 5'd18 || bus.piece_col !== 4'd4) begin n_fail++; $display("FAIL gravity_pos: got (%0d,%0d) expected (18,4)", bus.piece_row, bus.piece_col); end
    step(0, 1, 0, 0, lk, k, cyc);
    n_checks++; if (lk !== 1'b1 || cyc != ROWS + 1) begin n_fail++; $display("FAIL gravity_lock_cycles: got %0d busy cycles expected %0d", cyc, ROWS + 1); end
    n_checks++; if (bus.display_array[(18*COLS+4)*3 +: 6] !== {PC, PC} || bus.display_array[(19*COLS+4)*3 +: 6] !== {PC, PC}) begin
      n_fail++; $display("FAIL gravity_cells: rows18/19 got %h/%h expected %h", bus.display_array[(18*COLS+4)*3 +: 6], bus.display_array[(19*COLS+4)*3 +: 6], {PC, PC}); end
    n_checks++; if (bus.display_array !== exp_disp() || bus.piece_row !== 5'd0) begin n_fail++; $display("FAIL gravity_respawn: got %h row %0d expected %h row 0", bus.display_array, bus.piece_row, exp_disp()); end
  endtask

  task automatic test_walls();
    bit lk;
    int k, cyc;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, lk, k, cyc);
    n_checks++; if (bus.piece_col !== 4'd0) begin n_fail++; $display("FAIL walls_left_to_0: got %0d expected 0", bus.piece_col); end
    step(0, 0, 1, 0, lk, k, cyc);
    n_checks++; if (bus.piece_col !== 4'd0) begin n_fail++; $display("FAIL walls_left_edge: got %0d expected 0", bus.piece_col); end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, lk, k, cyc);
    n_checks++; if (bus.piece_col !== 4'd8) begin n_fail++; $display("FAIL walls_right_to_8: got %0d expected 8", bus.piece_col); end
    step(0, 0, 0, 1, lk, k, cyc);
    n_checks++; if (bus.piece_col !== 4'd8) begin n_fail++; $display("FAIL walls_right_edge: got %0d expected 8", bus.piece_col); end
    step(0, 0, 1, 1, lk, k, cyc);
    n_checks++; if (bus.piece_col !== 4'd8 || bus.display_array !== exp_disp()) begin n_fail++; $display("FAIL walls_both: got col %0d expected 8", bus.piece_col); end
  endtask

  task automatic test_line_clear();
    int k, cyc;
    do_reset();
    do_start();
    for (int p = 0; p < 4; p++) drop_at(2*p, k, cyc);
    n_checks++; if (bus.lines_cleared !== 16'd0) begin n_fail++; $display("FAIL line_partial: got %0d expected 0", bus.lines_cleared); end
    drop_at(8, k, cyc);
    n_checks++; if (cyc != ROWS + 5) begin n_fail++; $display("FAIL line_busy_cycles: got %0d expected %0d", cyc, ROWS + 5); end
    n_checks++; if (bus.lines_cleared !== 16'd2) begin n_fail++; $display("FAIL line_count: got %0d expected 2", bus.lines_cleared); end
    n_checks++; if (bus.display_array !== exp_disp() || bus.busy !== 1'b0) begin n_fail++; $display("FAIL line_board: got %h busy %b expected %h busy 0", bus.display_array, bus.busy, exp_disp()); end
  endtask

  task automatic test_game_over();
    int k, cyc;
    logic [W-1:0] snap;
    do_reset();
    do_start();
    for (int p = 0; p < 10; p++) drop_at(SPAWN_COL, k, cyc);
    n_checks++; if (bus.game_over !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL over_flag: got go %b busy %b expected 1 0", bus.game_over, bus.busy); end
    n_checks++; if (bus.display_array !== exp_disp()) begin n_fail++; $display("FAIL over_board: got %h expected %h", bus.display_array, exp_disp()); end
    snap = exp_disp();
    drive(0, 1, 0, 0); drive(0, 0, 1, 0); drive(0, 0, 0, 1);
    n_checks++; if (bus.display_array !== snap || bus.game_over !== 1'b1 || bus.piece_col !== 4'(SPAWN_COL)) begin
      n_fail++; $display("FAIL over_ignore: got %h go %b col %0d expected unchanged", bus.display_array, bus.game_over, bus.piece_col); end
    do_start();
    n_checks++; if (bus.display_array !== exp_disp() || bus.lines_cleared !== 16'd0 || bus.game_over !== 1'b0) begin
      n_fail++; $display("FAIL over_restart: got %h lines %0d go %b expected %h 0 0", bus.display_array, bus.lines_cleared, bus.game_over, exp_disp()); end
    n_checks++; if (bus.piece_row !== 5'd0 || bus.piece_col !== 4'(SPAWN_COL)) begin n_fail++; $display("FAIL over_restart_pos: got (%0d,%0d) expected (0,%0d)", bus.piece_row, bus.piece_col, SPAWN_COL); end
  endtask

  task automatic test_reset_mid_shift();
    bit lk;
    int k, cyc;
    do_reset();
    do_start();
    for (int p = 0; p < 4; p++) drop_at(2*p, k, cyc);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, lk, k, cyc);
    for (int i = 0; i < 18; i++) step(0, 1, 0, 0, lk, k, cyc);
    drive(0, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL shift_reached: busy got %b expected 1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.display_array !== '0 || bus.lines_cleared !== 16'd0 || bus.busy !== 1'b0 || bus.game_over !== 1'b0) begin
      n_fail++; $display("FAIL shift_reset_outputs: board %h lines %0d busy %b go %b expected all 0", bus.display_array, bus.lines_cleared, bus.busy, bus.game_over); end
    n_checks++; if (bus.piece_row !== 5'd0 || bus.piece_col !== 4'(SPAWN_COL)) begin n_fail++; $display("FAIL shift_reset_pos: got (%0d,%0d) expected (0,%0d)", bus.piece_row, bus.piece_col, SPAWN_COL); end
    rst = 1'b0;
    model_clear();
    mplay = 1'b0; mover = 1'b0; mrow = 0; mcol = SPAWN_COL; mlines = 0;
    drive(0, 1, 0, 0);
    n_checks++; if (bus.busy !== 1'b0 || bus.display_array !== '0) begin n_fail++; $display("FAIL shift_reset_idle: busy %b board %h expected idle", bus.busy, bus.display_array); end
  endtask

  task automatic test_random();
    bit lk, s, t, l, r;
    int k, cyc, sel;
    do_reset();
    do_start();
    for (int n = 0; n < 600; n++) begin
      if (mover) begin
        n_checks++; if (bus.game_over !== 1'b1) begin n_fail++; $display("FAIL rand_over[%0d]: got %b expected 1", n, bus.game_over); end
        do_start();
      end
      sel = int'($urandom_range(0, 99));
      s = (sel >= 95);
      t = (sel < 40) || (sel >= 97);
      l = (sel >= 40 && sel < 65) || (sel >= 90 && sel < 95);
      r = (sel >= 65 && sel < 90) || (sel >= 90 && sel < 95);
      step(s, t, l, r, lk, k, cyc);
      if (lk) begin
        n_checks++; if (cyc != ROWS + 1 + 2*k) begin n_fail++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", n, cyc, ROWS + 1 + 2*k); end
      end
      n_checks++; if (bus.piece_row !== 5'(mrow) || bus.piece_col !== 4'(mcol)) begin n_fail++; $display("FAIL rand_pos[%0d]: got (%0d,%0d) expected (%0d,%0d)", n, bus.piece_row, bus.piece_col, mrow, mcol); end
      n_checks++; if (bus.display_array !== exp_disp()) begin n_fail++; $display("FAIL rand_disp[%0d]: got %h expected %h", n, bus.display_array, exp_disp()); end
      n_checks++; if (bus.lines_cleared !== 16'(mlines) || bus.game_over !== mover) begin n_fail++; $display("FAIL rand_status[%0d]: lines %0d go %b expected %0d %b", n, bus.lines_cleared, bus.game_over, mlines, mover); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_gravity();
    test_walls();
    test_line_clear();
    test_game_over();
    test_reset_mid_shift();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
